// File: rtl/act_lut_pkg.sv
// Shared types and constants for the activation lookup-table writer.
// The FSM state enum, the checksum width and the checksum accumulate helper live here.
package act_lut_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } lut_state_e;

  localparam int CHECKSUM_W = 8;

  // Modulo-256 accumulate; the carry out of the top bit is dropped on purpose.
  function automatic logic [CHECKSUM_W-1:0] csum_add(
    input logic [CHECKSUM_W-1:0] acc,
    input logic [CHECKSUM_W-1:0] val
  );
    return acc + val;
  endfunction

endpackage

// File: rtl/act_lut_ram.sv
// Lookup-table storage: 2^ADDR_W x DATA_W entries with one synchronous write port
// and one registered read port. The read register holds its value when i_re is low.
module act_lut_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Table write port; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port, cleared by reset so the result bus starts at zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdata <= {DATA_W{1'b0}};
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/act_lut_writer.sv
// Loadable activation lookup table: sequential config load, then latency-1 lookups.
// Optional macro LUT_CHECKSUM_EN builds a modulo-256 checksum of the loaded entries.
module act_lut_writer
  import act_lut_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0  = 4,
  parameter int DATA_OUT_0_PRECISION_0 = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_OUT_0_PRECISION_0-1:0] cfg_data,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic                              cfg_last,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready,
  output logic                              table_loaded,
  output logic                              cfg_error,
  output logic [CHECKSUM_W-1:0]             checksum
);

  localparam int N = DATA_IN_0_PRECISION_0;
  localparam int W = DATA_OUT_0_PRECISION_0;
  localparam logic [N-1:0] ADDR_ZERO = N'(0);
  localparam logic [N-1:0] ADDR_ONE  = N'(1);
  localparam logic [N-1:0] ADDR_LAST = {N{1'b1}};

  lut_state_e r_state;
  lut_state_e w_state_nxt;
  logic [N-1:0] r_wptr;
  logic [N-1:0] w_wptr_nxt;
  logic [N-1:0] w_waddr;
  logic         r_out_valid;
  logic         w_out_valid_nxt;
  logic         r_cfg_error;
  logic         w_cfg_error_nxt;
  logic         w_cfg_ready;
  logic         w_in_ready;
  logic         w_cfg_fire;
  logic         w_lookup_fire;
  logic [W-1:0] w_rdata;

  // Handshake readies; in READY a pending lookup blocks the config port.
  always_comb begin
    w_cfg_ready = 1'b0;
    w_in_ready  = 1'b0;
    case (r_state)
      EMPTY, LOADING: begin
        w_cfg_ready = 1'b1;
        w_in_ready  = 1'b0;
      end
      READY: begin
        w_in_ready  = !r_out_valid || data_out_0_ready;
        w_cfg_ready = !r_out_valid && !data_in_0_valid;
      end
      default: begin
        w_cfg_ready = 1'b0;
        w_in_ready  = 1'b0;
      end
    endcase
  end

  assign w_cfg_fire    = cfg_valid && w_cfg_ready;
  assign w_lookup_fire = data_in_0_valid && w_in_ready;

  // FSM next state, write pointer and sticky malformed-load flag.
  always_comb begin
    w_state_nxt     = r_state;
    w_wptr_nxt      = r_wptr;
    w_cfg_error_nxt = r_cfg_error;
    w_waddr         = r_wptr;
    case (r_state)
      EMPTY, READY: begin
        w_waddr = ADDR_ZERO;
        if (w_cfg_fire) begin
          w_state_nxt     = LOADING;
          w_wptr_nxt      = ADDR_ONE;
          w_cfg_error_nxt = cfg_last;
        end else begin
          w_state_nxt = r_state;
        end
      end
      LOADING: begin
        w_waddr = r_wptr;
        if (w_cfg_fire) begin
          if (r_wptr == ADDR_LAST) begin
            w_state_nxt     = READY;
            w_wptr_nxt      = ADDR_ZERO;
            w_cfg_error_nxt = r_cfg_error || !cfg_last;
          end else begin
            w_wptr_nxt      = r_wptr + ADDR_ONE;
            w_cfg_error_nxt = r_cfg_error || cfg_last;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
        w_wptr_nxt  = ADDR_ZERO;
        w_waddr     = ADDR_ZERO;
      end
    endcase
  end

  // Output valid: set by an accepted lookup, cleared when the consumer takes it.
  always_comb begin
    if (w_lookup_fire) begin
      w_out_valid_nxt = 1'b1;
    end else if (data_out_0_ready) begin
      w_out_valid_nxt = 1'b0;
    end else begin
      w_out_valid_nxt = r_out_valid;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= EMPTY;
      r_wptr      <= ADDR_ZERO;
      r_out_valid <= 1'b0;
      r_cfg_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wptr      <= w_wptr_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_cfg_error <= w_cfg_error_nxt;
    end
  end

`ifdef LUT_CHECKSUM_EN
  logic [CHECKSUM_W-1:0] r_checksum;
  logic [CHECKSUM_W-1:0] w_cfg_byte;
  logic                  w_restart;

  generate
    if (W >= CHECKSUM_W) begin : g_trunc
      assign w_cfg_byte = cfg_data[CHECKSUM_W-1:0];
    end else begin : g_zext
      assign w_cfg_byte = {{(CHECKSUM_W-W){1'b0}}, cfg_data};
    end
  endgenerate

  assign w_restart = (r_state != LOADING);

  // Checksum restarts with the first beat of every load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_checksum <= {CHECKSUM_W{1'b0}};
    end else if (w_cfg_fire) begin
      r_checksum <= w_restart ? w_cfg_byte : csum_add(r_checksum, w_cfg_byte);
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = {CHECKSUM_W{1'b0}};
`endif

  act_lut_ram #(
    .ADDR_W (N),
    .DATA_W (W)
  ) u_ram (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_we    (w_cfg_fire),
    .i_waddr (w_waddr),
    .i_wdata (cfg_data),
    .i_re    (w_lookup_fire),
    .i_raddr (data_in_0),
    .o_rdata (w_rdata)
  );

  assign cfg_ready        = w_cfg_ready;
  assign data_in_0_ready  = w_in_ready;
  assign data_out_0       = w_rdata;
  assign data_out_0_valid = r_out_valid;
  assign table_loaded     = (r_state == READY);
  assign cfg_error        = r_cfg_error;

endmodule

// File: tb/tb_act_lut_writer.sv
// Directed self-checking bench for act_lut_writer (default 4-bit index / 4-bit entries).
module tb_act_lut_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_last;
  logic [3:0] data_in_0;
  logic       data_in_0_valid;
  logic       data_in_0_ready;
  logic [3:0] data_out_0;
  logic       data_out_0_valid;
  logic       data_out_0_ready;
  logic       table_loaded;
  logic       cfg_error;
  logic [7:0] checksum;

  int n_pass  = 0;
  int n_total = 0;
  int n_out_xfer = 0;
  logic [3:0] tbl [16];
  logic [7:0] exp_csum;

  always #5 clk = ~clk;

  act_lut_writer dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_data         (cfg_data),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_last         (cfg_last),
    .data_in_0        (data_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .data_out_0       (data_out_0),
    .data_out_0_valid (data_out_0_valid),
    .data_out_0_ready (data_out_0_ready),
    .table_loaded     (table_loaded),
    .cfg_error        (cfg_error),
    .checksum         (checksum)
  );

  // Count output transfers at the negedge preceding the edge that performs them.
  always @(negedge clk) begin
    if (data_out_0_valid === 1'b1 && data_out_0_ready === 1'b1) n_out_xfer++;
  end

  task automatic cfg_beat(input logic [3:0] d, input logic l);
    bit done;
    done = 1'b0;
    cfg_data = d; cfg_last = l; cfg_valid = 1'b1;
    for (int w = 0; w < 20 && !done; w++) begin
      @(negedge clk);
      if (cfg_ready === 1'b1) done = 1'b1;
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0; cfg_last = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL cfg_beat_timeout: cfg_ready never high, data=%h", d);
    end
  endtask

  task automatic do_lookup(input logic [3:0] idx);
    bit done;
    done = 1'b0;
    data_in_0 = idx; data_in_0_valid = 1'b1;
    for (int w = 0; w < 20 && !done; w++) begin
      @(negedge clk);
      if (data_in_0_ready === 1'b1) done = 1'b1;
      @(posedge clk); #1;
    end
    data_in_0_valid = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL lookup_timeout: data_in_0_ready never high, idx=%h", idx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cfg_data = 4'h0; cfg_valid = 1'b0; cfg_last = 1'b0;
    data_in_0 = 4'h0; data_in_0_valid = 1'b0; data_out_0_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (data_out_0_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", data_out_0_valid); else n_pass++;
    n_total++; if (data_out_0 !== 4'h0) $display("FAIL rst_out_data: got %h want 0", data_out_0); else n_pass++;
    n_total++; if (table_loaded !== 1'b0) $display("FAIL rst_loaded: got %b want 0", table_loaded); else n_pass++;
    n_total++; if (cfg_error !== 1'b0) $display("FAIL rst_cfg_error: got %b want 0", cfg_error); else n_pass++;
    n_total++; if (checksum !== 8'h00) $display("FAIL rst_checksum: got %h want 00", checksum); else n_pass++;
    n_total++; if (cfg_ready !== 1'b1) $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); else n_pass++;
    n_total++; if (data_in_0_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", data_in_0_ready); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_load();
    for (int i = 0; i < 16; i++) begin
      cfg_beat(tbl[i], (i == 15));
      if (i == 14) begin
        n_total++; if (table_loaded !== 1'b0) $display("FAIL load_early_ready: got %b want 0", table_loaded); else n_pass++;
      end
    end
    n_total++; if (table_loaded !== 1'b1) $display("FAIL load_ready: got %b want 1", table_loaded); else n_pass++;
    n_total++; if (cfg_error !== 1'b0) $display("FAIL load_cfg_error: got %b want 0", cfg_error); else n_pass++;
    n_total++; if (checksum !== exp_csum) $display("FAIL load_checksum: got %h want %h", checksum, exp_csum); else n_pass++;
  endtask

  task automatic test_lookup();
    logic [3:0] idx [5];
    logic [3:0] exp [5];
    idx = '{4'h4, 4'h8, 4'h0, 4'hF, 4'h3};
    exp = '{4'h3, 4'hF, 4'h0, 4'h0, 4'h2};
    data_out_0_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_lookup(idx[i]);
      n_total++; if (data_out_0_valid !== 1'b1) $display("FAIL lookup_valid[%0d]: got %b want 1", i, data_out_0_valid); else n_pass++;
      n_total++; if (data_out_0 !== exp[i]) $display("FAIL lookup_data[%0d]: got %h want %h", i, data_out_0, exp[i]); else n_pass++;
    end
    @(posedge clk); #1;
    n_total++; if (data_out_0_valid !== 1'b0) $display("FAIL lookup_drain: got %b want 0", data_out_0_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int x0;
    x0 = n_out_xfer;
    data_out_0_ready = 1'b0;
    data_in_0 = 4'h7; data_in_0_valid = 1'b1;
    @(posedge clk); #1;
    data_in_0 = 4'h8;
    n_total++; if (data_out_0 !== 4'h6 || data_out_0_valid !== 1'b1) $display("FAIL b2b_first: got %h/%b want 6/1", data_out_0, data_out_0_valid); else n_pass++;
    n_total++; if (data_in_0_ready !== 1'b0) $display("FAIL b2b_stall_ready: got %b want 0", data_in_0_ready); else n_pass++;
    repeat (2) begin
      @(posedge clk); #1;
      n_total++; if (data_out_0 !== 4'h6 || data_out_0_valid !== 1'b1) $display("FAIL b2b_hold: got %h/%b want 6/1", data_out_0, data_out_0_valid); else n_pass++;
    end
    data_out_0_ready = 1'b1;
    @(posedge clk); #1;
    data_in_0 = 4'hF;
    n_total++; if (data_out_0 !== 4'hF || data_out_0_valid !== 1'b1) $display("FAIL b2b_second: got %h/%b want F/1", data_out_0, data_out_0_valid); else n_pass++;
    @(posedge clk); #1;
    data_in_0_valid = 1'b0;
    n_total++; if (data_out_0 !== 4'h0 || data_out_0_valid !== 1'b1) $display("FAIL b2b_third: got %h/%b want 0/1", data_out_0, data_out_0_valid); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (data_out_0_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", data_out_0_valid); else n_pass++;
    n_total++; if (n_out_xfer - x0 !== 3) $display("FAIL b2b_count: got %0d want 3", n_out_xfer - x0); else n_pass++;
  endtask

  task automatic test_bad_last();
    for (int i = 0; i < 16; i++) begin
      cfg_beat(tbl[i], (i == 9));
      if (i == 9) begin
        n_total++; if (cfg_error !== 1'b1) $display("FAIL bad_last_error: got %b want 1", cfg_error); else n_pass++;
      end
    end
    n_total++; if (table_loaded !== 1'b1) $display("FAIL bad_last_ready: got %b want 1", table_loaded); else n_pass++;
    n_total++; if (cfg_error !== 1'b1) $display("FAIL bad_last_sticky: got %b want 1", cfg_error); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      cfg_beat(tbl[i], (i == 15));
      if (i == 0) begin
        n_total++; if (cfg_error !== 1'b0) $display("FAIL reload_clear: got %b want 0", cfg_error); else n_pass++;
      end
    end
    n_total++; if (table_loaded !== 1'b1 || cfg_error !== 1'b0) $display("FAIL reload_ok: got %b/%b want 1/0", table_loaded, cfg_error); else n_pass++;
  endtask

  task automatic test_cfg_blocked();
    data_out_0_ready = 1'b0;
    data_in_0 = 4'h4; data_in_0_valid = 1'b1;
    cfg_data = tbl[0]; cfg_last = 1'b0; cfg_valid = 1'b1;
    @(negedge clk);
    n_total++; if (cfg_ready !== 1'b0) $display("FAIL blk_priority: got %b want 0", cfg_ready); else n_pass++;
    @(posedge clk); #1;
    data_in_0_valid = 1'b0;
    n_total++; if (data_out_0 !== 4'h3 || data_out_0_valid !== 1'b1) $display("FAIL blk_lookup: got %h/%b want 3/1", data_out_0, data_out_0_valid); else n_pass++;
    @(negedge clk);
    n_total++; if (cfg_ready !== 1'b0) $display("FAIL blk_pending1: got %b want 0", cfg_ready); else n_pass++;
    @(posedge clk); #1;
    data_out_0_ready = 1'b1;
    @(negedge clk);
    n_total++; if (cfg_ready !== 1'b0) $display("FAIL blk_pending2: got %b want 0", cfg_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (data_out_0_valid !== 1'b0 || table_loaded !== 1'b1) $display("FAIL blk_drained: got %b/%b want 0/1", data_out_0_valid, table_loaded); else n_pass++;
    @(negedge clk);
    n_total++; if (cfg_ready !== 1'b1) $display("FAIL blk_released: got %b want 1", cfg_ready); else n_pass++;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    n_total++; if (table_loaded !== 1'b0) $display("FAIL blk_loading: got %b want 0", table_loaded); else n_pass++;
    for (int i = 1; i < 16; i++) cfg_beat(tbl[i], (i == 15));
    n_total++; if (table_loaded !== 1'b1 || cfg_error !== 1'b0) $display("FAIL blk_reload: got %b/%b want 1/0", table_loaded, cfg_error); else n_pass++;
    n_total++; if (checksum !== exp_csum) $display("FAIL blk_checksum: got %h want %h", checksum, exp_csum); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 9; i++) cfg_beat(tbl[i], 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_total++; if (table_loaded !== 1'b0) $display("FAIL mid_rst_loaded: got %b want 0", table_loaded); else n_pass++;
    n_total++; if (checksum !== 8'h00 || cfg_error !== 1'b0) $display("FAIL mid_rst_regs: got %h/%b want 00/0", checksum, cfg_error); else n_pass++;
    data_in_0 = 4'h4; data_in_0_valid = 1'b1;
    @(negedge clk);
    n_total++; if (data_in_0_ready !== 1'b0) $display("FAIL mid_rst_refuse: got %b want 0", data_in_0_ready); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    data_in_0_valid = 1'b0;
    n_total++; if (data_out_0_valid !== 1'b0) $display("FAIL mid_rst_no_out: got %b want 0", data_out_0_valid); else n_pass++;
    for (int i = 0; i < 16; i++) cfg_beat(tbl[i], (i == 15));
    n_total++; if (table_loaded !== 1'b1 || cfg_error !== 1'b0) $display("FAIL mid_rst_reload: got %b/%b want 1/0", table_loaded, cfg_error); else n_pass++;
    n_total++; if (checksum !== exp_csum) $display("FAIL mid_rst_checksum: got %h want %h", checksum, exp_csum); else n_pass++;
    data_out_0_ready = 1'b1;
    do_lookup(4'h4);
    n_total++; if (data_out_0 !== 4'h3 || data_out_0_valid !== 1'b1) $display("FAIL mid_rst_lookup: got %h/%b want 3/1", data_out_0, data_out_0_valid); else n_pass++;
  endtask

  initial begin
    tbl = '{4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
            4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
`ifdef LUT_CHECKSUM_EN
    exp_csum = 8'h7F;
`else
    exp_csum = 8'h00;
`endif
    test_reset();
    test_load();
    test_lookup();
    test_back_to_back();
    test_bad_last();
    test_cfg_blocked();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
